// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x3 keypad matrix scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned ROW_W    = 2;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DIV_W    = 16;

    localparam logic [CODE_W-1:0]   KEY_NONE  = 4'd0;
    localparam logic [NUM_COLS-1:0] COL_RESET = 3'b110;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Key numbering runs row-major from 1 so that 0 can mean "no key yet".
    function automatic logic [CODE_W-1:0] key_encode(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return CODE_W'(row) * CODE_W'(NUM_COLS) + CODE_W'(col) + CODE_W'(1);
    endfunction

    function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_W-1:0] col);
        return ~(NUM_COLS'(1) << col);
    endfunction

    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] col);
        return (col == COL_W'(NUM_COLS - 1)) ? '0 : col + COL_W'(1);
    endfunction

endpackage

// File: rtl/keypad_matrix_reader_if.sv
// Bundle of keypad-side and key-event signals around keypad_matrix_reader.
interface keypad_matrix_reader_if;

    logic [keypad_pkg::NUM_ROWS-1:0] row_in;
    logic [keypad_pkg::NUM_COLS-1:0] col_out;
    logic [keypad_pkg::CODE_W-1:0]   key_code;
    logic                            key_valid;
    logic                            key_held;

    // master drives the keypad rows and observes key events; slave is the reader
    modport master (output row_in, input col_out, key_code, key_valid, key_held);
    modport slave  (input row_in, output col_out, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_matrix_reader_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_reader.sv
// Scans a 4x3 active-low keypad, debounces presses/releases and reports key events.
module keypad_matrix_reader
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    dwell_cnt;
    logic                dwell_end;
    logic [COL_W-1:0]    col_idx, col_nxt;
    logic [CNT_W-1:0]    deb_cnt, deb_nxt;
    logic [CODE_W-1:0]   cand_code, cand_nxt;
    logic [CODE_W-1:0]   code_nxt;
    logic                valid_nxt, held_nxt;

    logic [NUM_ROWS-1:0] row_s;
    logic [2:0]          low_cnt;
    logic [ROW_W-1:0]    hit_row;
    logic                hit, all_high;
    logic [CODE_W-1:0]   sample_code;

    sync_2ff #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    assign dwell_end = (dwell_cnt == DIV_W'(SCAN_DIV - 1));

    // A hit is exactly one low row; two or more low rows are treated as ghosting.
    always_comb begin
        low_cnt = '0;
        hit_row = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (!row_s[i]) begin
                low_cnt = low_cnt + 3'd1;
                hit_row = ROW_W'(i);
            end
        end
    end

    assign hit         = (low_cnt == 3'd1);
    assign all_high    = (row_s == {NUM_ROWS{1'b1}});
    assign sample_code = key_encode(hit_row, col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            dwell_cnt <= '0;
            col_idx   <= '0;
            col_out   <= COL_RESET;
            deb_cnt   <= '0;
            cand_code <= KEY_NONE;
            key_code  <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_end ? '0 : dwell_cnt + DIV_W'(1);
            col_idx   <= col_nxt;
            col_out   <= col_strobe(col_nxt);
            deb_cnt   <= deb_nxt;
            cand_code <= cand_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
        end
    end

    // The column only moves at a dwell end, and stays frozen while a key is being tracked.
    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        deb_nxt   = deb_cnt;
        cand_nxt  = cand_code;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;

        case (state)
            SCAN: begin
                if (dwell_end) begin
                    if (hit) begin
                        cand_nxt  = sample_code;
                        deb_nxt   = CNT_W'(1);
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_nxt = col_next(col_idx);
                    end
                end
            end

            DEBOUNCE: begin
                if (deb_cnt == CNT_W'(DEB_SAMPLES)) begin
                    valid_nxt = 1'b1;
                    code_nxt  = cand_code;
                    held_nxt  = 1'b1;
                    deb_nxt   = '0;
                    state_nxt = PRESSED;
                end else if (dwell_end) begin
                    if (hit && (sample_code == cand_code)) begin
                        deb_nxt = deb_cnt + CNT_W'(1);
                    end else begin
                        deb_nxt   = '0;
                        col_nxt   = col_next(col_idx);
                        state_nxt = SCAN;
                    end
                end
            end

            PRESSED: begin
                if (dwell_end && all_high) begin
                    deb_nxt   = CNT_W'(1);
                    state_nxt = RELEASE_WAIT;
                end
            end

            RELEASE_WAIT: begin
                if (dwell_end) begin
                    if (!all_high) begin
                        deb_nxt   = '0;
                        state_nxt = PRESSED;
                    end else if (deb_cnt == CNT_W'(DEB_SAMPLES - 1)) begin
                        deb_nxt   = '0;
                        held_nxt  = 1'b0;
                        col_nxt   = col_next(col_idx);
                        state_nxt = SCAN;
                    end else begin
                        deb_nxt = deb_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_matrix_reader.sv
// Directed scoreboard bench for keypad_matrix_reader with SCAN_DIV=4, DEB_SAMPLES=3.
module tb_keypad_matrix_reader;

    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned DEB_SAMPLES = 3;

    logic clk = 1'b0;
    logic rst_n;

    keypad_matrix_reader_if kif ();

    keypad_matrix_reader #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .row_in    (kif.row_in),
        .col_out   (kif.col_out),
        .key_code  (kif.key_code),
        .key_valid (kif.key_valid),
        .key_held  (kif.key_held)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Physical keypad: a pressed key pulls its row low while its column is strobed.
    logic [11:0] keys;
    logic        raw_en;
    logic [3:0]  raw_rows;

    always_comb begin
        kif.row_in = 4'hF;
        if (raw_en) begin
            kif.row_in = raw_rows;
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 3; c++)
                    if (keys[r*3 + c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
        end
    end

    // Cycle count since reset release; dwell edges land where cyc is a multiple of SCAN_DIV.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: log every key_valid pulse and any pulse longer than one cycle.
    logic [3:0] obs_codes [0:63];
    int         obs_n       = 0;
    int         long_pulses = 0;
    logic       prev_valid  = 1'b0;
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            if (obs_n < 64) obs_codes[obs_n] = kif.key_code;
            obs_n = obs_n + 1;
            if (prev_valid) long_pulses = long_pulses + 1;
        end
        prev_valid = (kif.key_valid === 1'b1);
    end

    logic [3:0] exp_q [$];
    int         rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step_dwell();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((cyc % SCAN_DIV) != 0) && (n < 2 * SCAN_DIV));
    endtask

    task automatic wait_col(input logic [2:0] target, input string tag);
        int n = 0;
        while ((kif.col_out !== target) && (n < 8)) begin
            step_dwell();
            n++;
        end
        check(tag, 32'(kif.col_out), 32'(target));
    endtask

    task automatic sb_drain(input string tag);
        logic [3:0] exp_code;
        while (rd < obs_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: unexpected key_valid code=%0d expected none", tag, obs_codes[rd]);
            end else begin
                exp_code = exp_q.pop_front();
                check(tag, 32'(obs_codes[rd]), 32'(exp_code));
            end
            rd++;
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] seq [3];
        int         base;
        seq[0] = 3'b101;
        seq[1] = 3'b011;
        seq[2] = 3'b110;

        keys     = '0;
        raw_en   = 1'b0;
        raw_rows = 4'hF;
        rst_n    = 1'b0;
        #23;
        check("rst_col",   32'(kif.col_out),   32'(3'b110));
        check("rst_code",  32'(kif.key_code),  32'd0);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_held",  32'(kif.key_held),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle rotation
        for (int i = 0; i < 6; i++) begin
            step_dwell();
            check("idle_col", 32'(kif.col_out), 32'(seq[i % 3]));
        end
        check("idle_pulses", 32'(obs_n), 32'd0);

        // Row 2 on column 1 -> code 8; column frozen until release is debounced
        keys[7] = 1'b1;
        exp_q.push_back(4'd8);
        wait_col(3'b101, "k8_wait");
        for (int i = 0; i < 3; i++) begin
            step_dwell();
            check("k8_frozen", 32'(kif.col_out), 32'(3'b101));
        end
        step_dwell();
        check("k8_held",   32'(kif.key_held), 32'd1);
        check("k8_code",   32'(kif.key_code), 32'd8);
        check("k8_pulses", 32'(obs_n),        32'd1);
        sb_drain("k8_sb");
        step_dwell();
        check("k8_hold_pulses", 32'(obs_n), 32'd1);
        keys = '0;
        for (int i = 0; i < 2; i++) begin
            step_dwell();
            check("k8_rel_held", 32'(kif.key_held), 32'd1);
            check("k8_rel_col",  32'(kif.col_out),  32'(3'b101));
        end
        step_dwell();
        check("k8_released", 32'(kif.key_held), 32'd0);
        check("k8_resume",   32'(kif.col_out),  32'(3'b011));
        step_dwell();
        check("k8_rotate",   32'(kif.col_out),  32'(3'b110));
        check("k8_code_kept", 32'(kif.key_code), 32'd8);

        // Bounce: two hits then a no-press sample, then a stable press of row 0 col 2 -> code 3
        wait_col(3'b011, "b3_wait");
        keys[2] = 1'b1;
        step_dwell();
        check("b3_hit1_col", 32'(kif.col_out), 32'(3'b011));
        step_dwell();
        check("b3_hit2_col", 32'(kif.col_out), 32'(3'b011));
        keys[2] = 1'b0;
        step_dwell();
        check("b3_abort_col",    32'(kif.col_out), 32'(3'b110));
        check("b3_abort_pulses", 32'(obs_n),       32'd1);
        keys[2] = 1'b1;
        exp_q.push_back(4'd3);
        step_dwell();
        check("b3_rot1", 32'(kif.col_out), 32'(3'b101));
        step_dwell();
        check("b3_rot2", 32'(kif.col_out), 32'(3'b011));
        for (int i = 0; i < 3; i++) step_dwell();
        check("b3_not_yet", 32'(obs_n), 32'd1);
        step_dwell();
        check("b3_pulses", 32'(obs_n),        32'd2);
        check("b3_code",   32'(kif.key_code), 32'd3);
        check("b3_held",   32'(kif.key_held), 32'd1);
        sb_drain("b3_sb");
        keys = '0;
        for (int i = 0; i < 3; i++) step_dwell();
        check("b3_released", 32'(kif.key_held), 32'd0);

        // Ghosting: rows 0 and 1 low together never register
        raw_en   = 1'b1;
        raw_rows = 4'hF;
        wait_col(3'b110, "gh_wait");
        raw_rows = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            step_dwell();
            check("gh_col", 32'(kif.col_out), 32'(seq[i % 3]));
        end
        check("gh_pulses", 32'(obs_n),        32'd2);
        check("gh_held",   32'(kif.key_held), 32'd0);
        raw_en = 1'b0;

        // Release glitch on row 3 col 0 -> code 10
        wait_col(3'b110, "gl_wait");
        keys[9] = 1'b1;
        exp_q.push_back(4'd10);
        for (int i = 0; i < 4; i++) step_dwell();
        check("gl_held",   32'(kif.key_held), 32'd1);
        check("gl_code",   32'(kif.key_code), 32'd10);
        sb_drain("gl_sb");
        keys = '0;
        for (int i = 0; i < 2; i++) begin
            step_dwell();
            check("gl_partial_held", 32'(kif.key_held), 32'd1);
        end
        keys[9] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_dwell();
            check("gl_repress_held", 32'(kif.key_held), 32'd1);
            check("gl_repress_col",  32'(kif.col_out),  32'(3'b110));
        end
        check("gl_no_repulse", 32'(obs_n), 32'd3);
        keys = '0;
        for (int i = 0; i < 2; i++) step_dwell();
        check("gl_rel2_held", 32'(kif.key_held), 32'd1);
        step_dwell();
        check("gl_released",  32'(kif.key_held), 32'd0);
        check("gl_pulses",    32'(obs_n),        32'd3);

        // Reset in the middle of debouncing row 1 col 1 abandons the key
        wait_col(3'b101, "rd_wait");
        keys[4] = 1'b1;
        step_dwell();
        step_dwell();
        check("rd_pre_col", 32'(kif.col_out), 32'(3'b101));
        rst_n = 1'b0;
        #1;
        check("rd_col",   32'(kif.col_out),   32'(3'b110));
        check("rd_code",  32'(kif.key_code),  32'd0);
        check("rd_valid", 32'(kif.key_valid), 32'd0);
        check("rd_held",  32'(kif.key_held),  32'd0);
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rd_after_col", 32'(kif.col_out), 32'(3'b110));
        for (int i = 0; i < 4; i++) step_dwell();
        check("rd_pulses", 32'(obs_n), 32'd3);
        sb_drain("rd_sb");

        check("single_cycle_pulses", 32'(long_pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_reader.md
KEYPAD_MATRIX_READER -- requirements
Module: keypad_matrix_reader

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each column stays driven (dwell); legal range 4..65535.
REQ-002 SHALL have parameter DEB_SAMPLES, default 4, meaning consecutive matching dwell-end samples required to accept a press or a release; legal range 2..15.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this single clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col_out  output  3  column strobes, active-low one-hot.
REQ-007 SHALL have port key_code  output  4  last accepted key (1..12), or 0 = none since reset.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_held  output  1  level, high from acceptance until the release is accepted.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-011 SHALL run a dwell counter from 0 to SCAN_DIV-1; the dwell end is the cycle where count = SCAN_DIV-1, and the counter then wraps to 0.
REQ-012 SHALL sample the synchronized rows only at dwell end; a sample counts as a hit when exactly one row is low.
REQ-013 SHALL encode a key as row*3 + col + 1 (row 0..3, col 0..2, giving codes 1..12).
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED and RELEASE_WAIT; reset state is SCAN.
REQ-015 In SCAN, on a dwell end, SHALL advance col_out to the next column (0->1->2->0) unless the sample is a hit.
REQ-016 In SCAN, on a hit, SHALL latch the candidate code, freeze the column, set match count = 1, and go to DEBOUNCE.
REQ-017 In SCAN, SHALL ignore samples with zero rows low or two or more rows low (ghosting), and keep rotating.
REQ-018 In DEBOUNCE, on a sample equal to the candidate, SHALL increment the match count.
REQ-019 In DEBOUNCE, on a mismatch or no-press sample, SHALL clear the count and return to SCAN, resuming rotation from the next column.
REQ-020 When the count reaches DEB_SAMPLES, SHALL on the next cycle pulse key_valid for 1 cycle, load key_code with the candidate, set key_held = 1, and enter PRESSED.
REQ-021 In PRESSED, with the column still frozen, SHALL go to RELEASE_WAIT with release count = 1 on the first sample whose row bits are all high.
REQ-022 In PRESSED, SHALL ignore samples that show other keys pressed in the same column; no second key_valid.
REQ-023 In RELEASE_WAIT, SHALL count consecutive all-high samples.
REQ-024 In RELEASE_WAIT, any low row SHALL return the FSM to PRESSED with count 0, leaving key_held = 1.
REQ-025 In RELEASE_WAIT, when the count reaches DEB_SAMPLES, SHALL clear key_held and go to SCAN.
REQ-026 SHALL hold key_code unchanged between accepted presses.
REQ-027 SHALL make col_out a registered output that changes only at a dwell end or on reset.
REQ-028 SHALL produce key_valid at most once per physical press.

Reset
REQ-029 On rst low, SHALL immediately (asynchronously) force col_out = 3'b110, key_code = 0, key_valid = 0, key_held = 0, state = SCAN, all counters = 0, and synchronizer flops = 4'hF.
REQ-030 Reset asserted mid-debounce or mid-press SHALL abandon the key with no key_valid; after reset, scanning restarts at column 0.

Structure
REQ-031 SHALL define the FSM state encoding, KEY_NONE = 4'd0, NUM_ROWS = 4 and NUM_COLS = 3 in a shared package, keypad_pkg.
REQ-032 SHALL place the synchronizer in one sub-module, sync_2ff, parameterized by width; everything else is in keypad_matrix_reader.

Verification (SCAN_DIV=4, DEB_SAMPLES=3)
REQ-033 Idle, all rows high: col_out SHALL cycle 110->101->011 every 4 cycles, with key_valid never asserted.
REQ-034 Hold row 2 low while column 1 is driven: key_code SHALL = 8 with one key_valid pulse; col_out SHALL stay at 101 until 3 all-high samples follow the release, then rotation resumes.
REQ-035 Press with a bounce (2 hits, 1 no-press, then stable): key_valid SHALL occur only after 3 fresh consecutive hits, as exactly one pulse.
REQ-036 Rows 0 and 1 both low in SCAN: SHALL give no key_valid and uninterrupted rotation.
REQ-037 Release glitch (2 all-high samples, then low again): SHALL keep key_held = 1 with no new key_valid; a later full release clears key_held.
REQ-038 Assert rst during DEBOUNCE: outputs SHALL immediately go to their reset values; after release col_out = 110 and no key_valid.
